// File: rtl/switch_allocator.sv
// Router switch allocator: per-output round-robin arbitration with packet locking and credit tracking.
// Optional SA_CREDIT_BYPASS_EN lets a credit returned this cycle be spent in the same cycle.
module switch_allocator #(
  parameter int PORT_NUM    = 5,
  parameter int BUFFER_SIZE = 8,
  parameter int PORT_SIZE   = $clog2(PORT_NUM)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORT_NUM-1:0]                 request_i,
  input  logic [PORT_NUM-1:0][PORT_SIZE-1:0]  out_port_i,
  input  logic [PORT_NUM-1:0]                 head_i,
  input  logic [PORT_NUM-1:0]                 tail_i,
  input  logic [PORT_NUM-1:0]                 credit_i,
  output logic [PORT_NUM-1:0]                 grant_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]  xbar_sel_o,
  output logic [PORT_NUM-1:0]                 valid_o,
  output logic                                credit_err_o
);

  // state    | meaning
  // S_IDLE   | output free; eligible HEAD flits compete round-robin
  // S_LOCKED | output held by owner until its TAIL flit is granted
  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  localparam int CW = $clog2(BUFFER_SIZE + 1);

  state_e                              state_q [PORT_NUM];
  state_e                              state_d [PORT_NUM];
  logic [PORT_SIZE-1:0]                owner_q [PORT_NUM];
  logic [PORT_SIZE-1:0]                owner_d [PORT_NUM];
  logic [PORT_SIZE-1:0]                rr_q    [PORT_NUM];
  logic [PORT_SIZE-1:0]                rr_d    [PORT_NUM];
  logic [CW-1:0]                       credit_q[PORT_NUM];
  logic [CW-1:0]                       credit_d[PORT_NUM];
  logic [PORT_NUM-1:0]                 elig    [PORT_NUM];
  logic [PORT_SIZE-1:0]                win     [PORT_NUM];
  logic [PORT_NUM-1:0]                 credit_ok;
  logic [PORT_NUM-1:0]                 gnt_out;
  logic [PORT_NUM-1:0]                 valid_q;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]  xbar_q;
  logic                                err_q, err_d;

  always_comb begin
    for (int j = 0; j < PORT_NUM; j++) begin
`ifdef SA_CREDIT_BYPASS_EN
      credit_ok[j] = (credit_q[j] != '0) | credit_i[j];
`else
      credit_ok[j] = (credit_q[j] != '0);
`endif
      for (int i = 0; i < PORT_NUM; i++)
        elig[j][i] = request_i[i] & (out_port_i[i] == PORT_SIZE'(j)) & credit_ok[j];
    end
  end

  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    gnt_out = '0;
    grant_o = '0;
    for (int j = 0; j < PORT_NUM; j++) begin
      win[j]     = '0;
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      rr_d[j]    = rr_q[j];
      if (state_q[j] == S_IDLE) begin
        found = 1'b0;
        for (int k = 0; k < PORT_NUM; k++) begin
          idx = int'(rr_q[j]) + k;
          if (idx >= PORT_NUM) idx = idx - PORT_NUM;
          if (!found && elig[j][idx] && head_i[idx]) begin
            found  = 1'b1;
            win[j] = PORT_SIZE'(idx);
          end
        end
        if (found) begin
          gnt_out[j] = 1'b1;
          rr_d[j]    = (int'(win[j]) == PORT_NUM - 1) ? '0 : PORT_SIZE'(int'(win[j]) + 1);
          if (!tail_i[win[j]]) begin
            state_d[j] = S_LOCKED;
            owner_d[j] = win[j];
          end
        end
      end else if (elig[j][owner_q[j]]) begin
        // Locked: only the owner is considered; the pointer is left alone.
        win[j]     = owner_q[j];
        gnt_out[j] = 1'b1;
        if (tail_i[owner_q[j]]) state_d[j] = S_IDLE;
      end
      if (gnt_out[j]) grant_o[win[j]] = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    for (int j = 0; j < PORT_NUM; j++) begin
      credit_d[j] = credit_q[j];
      if (gnt_out[j] && !credit_i[j]) begin
        credit_d[j] = credit_q[j] - 1'b1;
      end else if (!gnt_out[j] && credit_i[j]) begin
        if (credit_q[j] == CW'(BUFFER_SIZE)) err_d = 1'b1;
        else                                 credit_d[j] = credit_q[j] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < PORT_NUM; j++) begin
        state_q[j]  <= S_IDLE;
        owner_q[j]  <= '0;
        rr_q[j]     <= '0;
        credit_q[j] <= CW'(BUFFER_SIZE);
      end
      valid_q <= '0;
      xbar_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int j = 0; j < PORT_NUM; j++) begin
        state_q[j]  <= state_d[j];
        owner_q[j]  <= owner_d[j];
        rr_q[j]     <= rr_d[j];
        credit_q[j] <= credit_d[j];
        if (gnt_out[j]) xbar_q[j] <= win[j];
      end
      valid_q <= gnt_out;
      err_q   <= err_d;
    end
  end

  assign valid_o      = valid_q;
  assign xbar_sel_o   = xbar_q;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator; expected values are hand-derived per vector.
module tb_switch_allocator;

`ifdef SA_CREDIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      request, head, tail, credit;
  logic [4:0][2:0] out_port;
  logic [4:0]      grant, valid;
  logic [4:0][2:0] xbar;
  logic            err;
  int              nvec = 0;
  int              nmis = 0;

  switch_allocator #(.PORT_NUM(5), .BUFFER_SIZE(8)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .request_i    (request),
    .out_port_i   (out_port),
    .head_i       (head),
    .tail_i       (tail),
    .credit_i     (credit),
    .grant_o      (grant),
    .xbar_sel_o   (xbar),
    .valid_o      (valid),
    .credit_err_o (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    request  = '0;
    head     = '0;
    tail     = '0;
    credit   = '0;
    out_port = '0;
  endtask

  task automatic send(input int i, input int p, input logic h, input logic t);
    request[i]  = 1'b1;
    out_port[i] = 3'(p);
    head[i]     = h;
    tail[i]     = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] rot [3];
    rot[0] = 5'b00001;
    rot[1] = 5'b00100;
    rot[2] = 5'b10000;
    clr();
    rst_n = 1'b0;
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_xbar",  xbar,  0);
    chk("rst_err",   err,   0);
    chk("rst_grant", grant, 0);
    #10 rst_n = 1'b1;

    // Single HEADTAIL, input 1 -> output 3
    tick(); clr(); send(1, 3, 1, 1); #1;
    chk("t1_grant", grant, 5'b00010);
    tick(); clr(); #1;
    chk("t1_valid", valid, 5'b01000);
    chk("t1_xbar3", xbar[3], 1);
    credit[3] = 1'b1;
    send(0, 3, 1, 1); #1;
    chk("t1_idle_wrap", grant, 5'b00001);

    // Round-robin rotation on output 1 with credit returned every cycle
    for (int c = 0; c < 6; c++) begin
      tick(); clr();
      send(0, 1, 1, 1); send(2, 1, 1, 1); send(4, 1, 1, 1);
      credit[1] = 1'b1;
      if (c == 0) credit[3] = 1'b1;
      #1;
      chk($sformatf("t2_rr%0d", c), grant, rot[c % 3]);
    end
    tick(); clr(); #1;
    chk("t2_no_err", err, 0);

    // Packet lock on output 4; rr_ptr[4] first moved past input 0
    tick(); clr(); send(1, 4, 1, 1); #1;
    chk("t3_pre", grant, 5'b00010);
    for (int c = 0; c < 4; c++) begin
      tick(); clr();
      send(2, 4, c == 0, c == 3);
      send(0, 4, 1, 0);
      #1;
      chk($sformatf("t3_pkt%0d", c), grant, 5'b00100);
      if (c == 1) begin
        chk("t3_valid", valid, 5'b10000);
        chk("t3_xbar4", xbar[4], 2);
      end
    end
    tick(); clr(); send(0, 4, 1, 0); #1;
    chk("t3_unblock", grant, 5'b00001);
    tick(); clr(); send(3, 4, 1, 1); send(1, 0, 0, 0); #1;
    chk("t3_xbar4b", xbar[4], 0);
    chk("t3_locked_ignore", grant, 0);

    // Credit exhaustion on output 2
    for (int c = 0; c < 8; c++) begin
      tick(); clr(); send(3, 2, 1, 1); #1;
      chk($sformatf("t4_flit%0d", c), grant, 5'b01000);
    end
    tick(); clr(); send(3, 2, 1, 1); #1;
    chk("t4_stall", grant, 0);
    chk("t4_valid_last", valid[2], 1);
    tick(); clr(); send(3, 2, 1, 1); #1;
    chk("t4_valid_idle", valid[2], 0);
    chk("t4_xbar_hold", xbar[2], 3);
    credit[2] = 1'b1; #1;
    chk("t4_credit_cyc", grant, BYP ? 5'b01000 : 5'b00000);
    tick(); clr(); send(3, 2, 1, 1); #1;
    chk("t4_after", grant, BYP ? 5'b00000 : 5'b01000);
    tick(); clr(); send(3, 2, 1, 1); #1;
    chk("t4_empty", grant, 0);
    chk("t4_no_err", err, 0);

    // Credit overflow on a full output is sticky
    tick(); clr(); credit[0] = 1'b1; #1;
    chk("t5_before", err, 0);
    tick(); clr(); #1;
    chk("t5_set", err, 1);
    tick(); tick();
    chk("t5_sticky", err, 1);

    // Async reset while output 4 is locked to input 0
    tick(); clr(); send(0, 4, 0, 0); #1;
    chk("t6_body", grant, 5'b00001);
    tick(); clr(); #1;
    chk("t6_valid", valid, 5'b10000);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_xbar",  xbar,  0);
    chk("t6_rst_err",   err,   0);
    #2 rst_n = 1'b1;
    tick(); clr(); send(3, 4, 1, 0); send(1, 2, 1, 1); #1;
    chk("t6_post_grant", grant, 5'b01010);
    tick(); clr(); #1;
    chk("t6_post_valid", valid, 5'b10100);
    chk("t6_post_xbar4", xbar[4], 3);
    chk("t6_post_xbar2", xbar[2], 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Router-level stage directly downstream of the input ports. It consumes each port's per-cycle request, consisting of the target output port and the head/tail flags of the flit at the buffer front.
- Arbitrates each output port round-robin and locks an output to one input for the whole packet (head to tail).
- Tracks downstream buffer credits per output port.
- Issues a same-cycle read grant to the winning input buffer, plus a registered crossbar select and valid one cycle later.

Parameters:
- PORT_NUM, 5, number of input and output ports (LOCAL, NORTH, SOUTH, WEST, EAST; index 0..4).
- BUFFER_SIZE, 8, depth of each downstream input buffer; initial and maximum credit count per output.
- PORT_SIZE, $clog2(PORT_NUM), width of a port index.

Ports:
- clk  input  1  router clock.
- rst  input  1  asynchronous, active-low reset.
- request_i  input  PORT_NUM  input i has a flit ready at its buffer front.
- out_port_i  input  PORT_NUM x PORT_SIZE  output port requested by input i (from routing computation).
- head_i  input  PORT_NUM  requesting flit of input i is HEAD (or HEADTAIL).
- tail_i  input  PORT_NUM  requesting flit of input i is TAIL (or HEADTAIL).
- credit_i  input  PORT_NUM  one credit returned by the downstream router on output j.
- grant_o  output  PORT_NUM  combinational; input i pops its buffer this cycle.
- xbar_sel_o  output  PORT_NUM x PORT_SIZE  registered; input index driving output j.
- valid_o  output  PORT_NUM  registered; output j carries a valid flit this cycle.
- credit_err_o  output  1  sticky; credit returned on an output already at BUFFER_SIZE.

Behaviour:
- Reset (rst low, asynchronous):
  - All credit counters = BUFFER_SIZE.
  - All output FSMs = IDLE; owner = 0.
  - Round-robin pointers = 0.
  - valid_o = 0, xbar_sel_o = 0, credit_err_o = 0.
  - grant_o is combinational and evaluates to 0 because no request is eligible.
- Eligibility of input i for output j: request_i[i] & out_port_i[i]==j & credit[j]>0.
- Per-output FSM, IDLE:
  - Only eligible inputs with head_i set compete.
  - The winner is the first eligible index at or after rr_ptr[j], wrapping modulo PORT_NUM.
  - On a grant, rr_ptr[j] <= winner+1 (PORT_NUM-1 wraps to 0).
  - If the winning flit is not tail: go to LOCKED and set owner[j] <= winner. A HEADTAIL flit leaves the FSM in IDLE.
- Per-output FSM, LOCKED:
  - Only owner[j] is considered. Requests from other inputs for output j are ignored, never granted.
  - An owner request without credit stalls: no grant, state is held.
  - A granted tail returns the FSM to IDLE. rr_ptr is unchanged.
- Grant rule: grant_o[i] is high iff input i wins its requested output. At most one grant per input and one per output per cycle.
- Credits, per output per cycle:
  - Grant without credit_i: counter -1.
  - credit_i without grant: counter +1.
  - Both: unchanged.
  - credit_i while counter==BUFFER_SIZE and no grant: counter holds, credit_err_o <= 1 until reset.
- Output timing:
  - Cycle t+1 after a grant at t: valid_o[j]=1, xbar_sel_o[j]=winner. This aligns with the buffer data read at t.
  - Cycle t+1 with no grant at t: valid_o[j]=0, xbar_sel_o[j] holds its previous value.
- Non-head request to an IDLE output: it is a protocol violation and is never granted.
- Reset mid-packet: locks are dropped and credits are restored. The upstream is reset concurrently.
- Latency: request to grant 0 cycles; grant to valid_o 1 cycle.

Optional Feature:
- Macro: SA_CREDIT_BYPASS_EN.
- Defined: the credit term in eligibility becomes (credit[j]>0 | credit_i[j]), so a credit returned in a cycle can be spent in that same cycle. A counter at 0 with credit_i and a grant stays 0.
- Undefined: eligibility uses the registered counter only. A returned credit is usable from the next cycle.

Test Plan:
- Reset, then input 1 sends a HEADTAIL to output 3 → grant_o=00010 same cycle; next cycle valid_o[3]=1, xbar_sel_o[3]=1; credit[3]=7; FSM stays IDLE.
- Inputs 0, 2, 4 each send a HEADTAIL to output 1 every cycle, with credit_i[1] returned every cycle → grants rotate 0,2,4,0,… and the credit count stays at 8.
- Input 2 sends HEAD, BODY, BODY, TAIL to output 4 while input 0 requests a HEAD to output 4 → input 0 is blocked for 4 cycles and granted in cycle 5.
- 8 flits to output 2 with no credits returned → 8 grants, then a stall with grant_o=0. One credit_i arrives → with SA_CREDIT_BYPASS_EN the grant occurs in that same cycle; without it, one cycle later.
- With credit[0]=8 and no traffic, pulse credit_i[0] → credit_err_o=1 next cycle; it stays 1 until rst is asserted low.
- Assert rst low mid-packet while output 4 is LOCKED → all outputs go to 0 immediately (asynchronously); after release, a HEAD from input 3 to output 4 is granted.
